// File: rtl/weight_serializer.sv
// Parallel-to-serial weight feeder: FIFO-buffered words shifted out one bit per clock with first/last framing.
// Optional build macro WSER_ZERO_SKIP_EN collapses all-zero words into a single-cycle zero frame.
module weight_serializer #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WEIGHT_WIDTH-1:0]         w_data,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic                            stall,
  output logic                            ser_bit,
  output logic                            ser_valid,
  output logic                            ser_first,
  output logic                            ser_last,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (WEIGHT_WIDTH > 1) ? $clog2(WEIGHT_WIDTH) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(WEIGHT_WIDTH - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [WEIGHT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q;
  logic [WEIGHT_WIDTH-1:0] sreg_q;
  logic [BW-1:0]           bcnt_q;
  logic                    first_q, last_q;
  logic [WEIGHT_WIDTH-1:0] head;
  logic                    fifo_ne, push, pop, last_bit, advance, load_zero;

  assign head     = mem[rd_ptr_q];
  assign w_ready  = (count_q < DEPTH_C);
  assign fifo_ne  = (count_q != '0);
  assign push     = w_valid & w_ready;
  assign last_bit = (state_q == SHIFT) && (bcnt_q == BCNT_LAST);
  assign pop      = fifo_ne & ~stall & ((state_q == IDLE) | last_bit);
  assign advance  = (state_q == SHIFT) & ~stall & ~last_bit;

`ifdef WSER_ZERO_SKIP_EN
  assign load_zero = (head == '0);
`else
  assign load_zero = 1'b0;
`endif

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= w_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SHIFT;
      SHIFT:   if (last_bit && !stall && !pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero word under skip loads with bcnt at its last value, so the
  // ordinary end-of-word path handles the 1-cycle frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q  <= '0;
      bcnt_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (pop) begin
      sreg_q  <= head;
      first_q <= 1'b1;
      if (load_zero) begin
        bcnt_q <= BCNT_LAST;
        last_q <= 1'b1;
      end else begin
        bcnt_q <= '0;
        last_q <= (WEIGHT_WIDTH == 1);
      end
    end else if (advance) begin
      sreg_q  <= MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
      bcnt_q  <= bcnt_q + 1'b1;
      first_q <= 1'b0;
      last_q  <= ((bcnt_q + 1'b1) == BCNT_LAST);
    end else if ((state_q == SHIFT) && !stall) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  always_comb begin
    ser_valid  = (state_q == SHIFT);
    ser_bit    = ser_valid & (MSB_FIRST ? sreg_q[WEIGHT_WIDTH-1] : sreg_q[0]);
    ser_first  = ser_valid & first_q;
    ser_last   = ser_valid & last_q;
    busy       = ser_valid | fifo_ne;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_weight_serializer.sv
// Directed bench for weight_serializer (WEIGHT_WIDTH=8, FIFO_DEPTH=4, LSB first).
module tb_weight_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] w_data = 8'h00;
  logic       w_valid = 1'b0;
  logic       stall = 1'b0;
  logic       w_ready, ser_bit, ser_valid, ser_first, ser_last, busy;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_serializer #(.WEIGHT_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .stall(stall), .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_first(ser_first),
    .ser_last(ser_last), .busy(busy), .fifo_count(fifo_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    #3;
    n_cmp++;
    if ({ser_valid, ser_first, ser_last, ser_bit, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs: got vflbB=%b need 00000", {ser_valid, ser_first, ser_last, ser_bit, busy});
    end
    n_cmp++;
    if ({w_ready, fifo_count} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_fifo: got ready=%b count=%0d need ready=1 count=0", w_ready, fifo_count);
    end
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_serialize();
    logic [7:0] wd;
    logic [3:0] exp;
    wd = 8'b01101001;
    w_data = wd; w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    n_cmp++;
    if ({fifo_count, ser_valid} !== {3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL ser_latency: got count=%0d valid=%b need count=1 valid=0", fifo_count, ser_valid);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), wd[i]};
      n_cmp++;
      if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
        n_err++;
        $display("FAIL serialize_bit%0d: got vflb=%b need %b", i, {ser_valid, ser_first, ser_last, ser_bit}, exp);
      end
      step();
    end
    n_cmp++;
    if ({ser_valid, ser_first, ser_last, ser_bit, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL serialize_end: got vflbB=%b need 00000", {ser_valid, ser_first, ser_last, ser_bit, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic [3:0]  exp;
    s = {8'h3C, 8'hA5};
    w_data = 8'hA5; w_valid = 1'b1;
    step();
    w_data = 8'h3C;
    step();
    w_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL b2b_count: got %0d need 1", fifo_count);
    end
    for (int i = 0; i < 16; i++) begin
      exp = {1'b1, (i % 8 == 0), (i % 8 == 7), s[i]};
      n_cmp++;
      if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
        n_err++;
        $display("FAIL b2b_bit%0d: got vflb=%b need %b", i, {ser_valid, ser_first, ser_last, ser_bit}, exp);
      end
      step();
    end
    n_cmp++;
    if (ser_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: got valid=%b need 0", ser_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0]  wv [5];
    logic [39:0] s;
    logic [3:0]  exp;
    wv = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE7};
    s  = {8'hE7, 8'h24, 8'hC3, 8'h42, 8'h81};
    stall = 1'b1; w_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w_data = wv[k];
      step();
    end
    n_cmp++;
    if ({fifo_count, w_ready, ser_valid, busy} !== {3'd4, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL full_state: got count=%0d ready=%b valid=%b busy=%b need 4 0 0 1",
               fifo_count, w_ready, ser_valid, busy);
    end
    w_data = wv[4];
    step();
    step();
    n_cmp++;
    if ({fifo_count, w_ready} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL full_hold: got count=%0d ready=%b need 4 0", fifo_count, w_ready);
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if ({fifo_count, w_ready} !== {3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL full_pop: got count=%0d ready=%b need 3 1", fifo_count, w_ready);
    end
    for (int i = 0; i < 40; i++) begin
      exp = {1'b1, (i % 8 == 0), (i % 8 == 7), s[i]};
      n_cmp++;
      if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
        n_err++;
        $display("FAIL full_stream_bit%0d: got vflb=%b need %b", i, {ser_valid, ser_first, ser_last, ser_bit}, exp);
      end
      step();
      if (i == 0) begin
        w_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== 3'd4) begin
          n_err++;
          $display("FAIL full_fifth_push: got count=%0d need 4", fifo_count);
        end
      end
    end
    n_cmp++;
    if ({ser_valid, fifo_count} !== 4'b0) begin
      n_err++;
      $display("FAIL full_drain: got valid=%b count=%0d need 0 0", ser_valid, fifo_count);
    end
  endtask

  task automatic test_stall();
    logic [7:0] wd;
    logic [3:0] exp;
    wd = 8'hF0;
    w_data = wd; w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), wd[i]};
      n_cmp++;
      if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
        n_err++;
        $display("FAIL stall_bit%0d: got vflb=%b need %b", i, {ser_valid, ser_first, ser_last, ser_bit}, exp);
      end
      if (i == 3) begin
        stall = 1'b1;
        for (int h = 0; h < 3; h++) begin
          step();
          n_cmp++;
          if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
            n_err++;
            $display("FAIL stall_hold%0d: got vflb=%b need %b", h, {ser_valid, ser_first, ser_last, ser_bit}, exp);
          end
        end
        stall = 1'b0;
      end
      step();
    end
    n_cmp++;
    if (ser_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: got valid=%b need 0", ser_valid);
    end
  endtask

  task automatic test_reset_midword();
    w_data = 8'h5A; w_valid = 1'b1;
    step();
    w_data = 8'hB2;
    step();
    w_data = 8'hC7;
    step();
    w_valid = 1'b0;
    step();
    step();
    step();
    n_cmp++;
    if ({ser_valid, ser_first, ser_last, ser_bit, fifo_count} !== {4'b1001, 3'd2}) begin
      n_err++;
      $display("FAIL midword_pre: got vflb=%b count=%0d need 1001 2",
               {ser_valid, ser_first, ser_last, ser_bit}, fifo_count);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ser_valid, ser_first, ser_last, ser_bit, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL midword_reset_outs: got vflbB=%b need 00000", {ser_valid, ser_first, ser_last, ser_bit, busy});
    end
    n_cmp++;
    if ({w_ready, fifo_count} !== 4'b1000) begin
      n_err++;
      $display("FAIL midword_reset_fifo: got ready=%b count=%0d need 1 0", w_ready, fifo_count);
    end
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if ({ser_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL midword_after%0d: got valid=%b busy=%b need 0 0", c, ser_valid, busy);
      end
    end
  endtask

  task automatic test_zero_word();
    logic [3:0]  exp;
    logic [15:0] s;
    s = {8'h01, 8'h00};
    w_data = 8'h00; w_valid = 1'b1;
    step();
    w_data = 8'h01;
    step();
    w_valid = 1'b0;
`ifdef WSER_ZERO_SKIP_EN
    n_cmp++;
    if ({ser_valid, ser_first, ser_last, ser_bit} !== 4'b1110) begin
      n_err++;
      $display("FAIL zero_frame: got vflb=%b need 1110", {ser_valid, ser_first, ser_last, ser_bit});
    end
    step();
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), s[8 + i]};
      n_cmp++;
      if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
        n_err++;
        $display("FAIL zero_next_bit%0d: got vflb=%b need %b", i, {ser_valid, ser_first, ser_last, ser_bit}, exp);
      end
      step();
    end
`else
    for (int i = 0; i < 16; i++) begin
      exp = {1'b1, (i % 8 == 0), (i % 8 == 7), s[i]};
      n_cmp++;
      if ({ser_valid, ser_first, ser_last, ser_bit} !== exp) begin
        n_err++;
        $display("FAIL zero_bit%0d: got vflb=%b need %b", i, {ser_valid, ser_first, ser_last, ser_bit}, exp);
      end
      step();
    end
`endif
    n_cmp++;
    if ({ser_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL zero_end: got valid=%b busy=%b need 0 0", ser_valid, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_serialize();
    test_back_to_back();
    test_fifo_full();
    test_stall();
    test_reset_midword();
    test_zero_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
